// File: rtl/real_dom_gf4_inv_out_stage_if.sv
// Bundle between the masked GF(2^4) inverter core and its output stage:
// shared products and randomness in, refreshed shared inverse and status out.
interface real_dom_gf4_inv_out_stage_if #(
  parameter int SHARES = 2
);
  logic                    ValidxSI;
  logic [2*SHARES-1:0]     _AmulExDI;
  logic [2*SHARES-1:0]     _BmulExDI;
  logic [4*(SHARES-1)-1:0] _RxDI;
  logic [4*SHARES-1:0]     _QxDO;
  logic                    ValidxSO;
  logic                    BusyxSO;

  modport master (
    output ValidxSI, _AmulExDI, _BmulExDI, _RxDI,
    input  _QxDO, ValidxSO, BusyxSO
  );

  modport slave (
    input  ValidxSI, _AmulExDI, _BmulExDI, _RxDI,
    output _QxDO, ValidxSO, BusyxSO
  );
endinterface

// File: rtl/real_dom_gf4_inv_out_stage.sv
// Output stage of the masked GF(2^4) inverter: reassembles A*E / B*E shares into
// the 4-bit shared inverse, refreshes them, registers them and tracks valid tokens.
module real_dom_gf4_inv_out_stage #(
  parameter int SHARES     = 2,
  parameter int LATENCY_IN = 2
) (
  input  logic                          ClkxCI,
  input  logic                          RstxBI,
  real_dom_gf4_inv_out_stage_if.slave   io
);

  localparam int CNT_W = $clog2(LATENCY_IN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY_IN + 1);

  logic [LATENCY_IN-1:0] valid_sr_q, valid_sr_d;
  logic                  stage_valid;
  logic [4*SHARES-1:0]   q_q, q_d;
  logic                  valid_out_q, valid_out_d;
  logic [CNT_W-1:0]      occ_cnt_q, occ_cnt_d;
  logic                  busy_q, busy_d;
  logic [3:0]            r_sum;
  logic [3:0]            ref_share [SHARES];

  // Token shift register mirrors the upstream core's pipeline depth.
  always_comb begin
    valid_sr_d    = valid_sr_q;
    valid_sr_d[0] = io.ValidxSI;
    for (int k = 1; k < LATENCY_IN; k++) begin
      valid_sr_d[k] = valid_sr_q[k-1];
    end
  end

  assign stage_valid = valid_sr_q[LATENCY_IN-1];

  // The last share absorbs every refresh word so the share XOR is unchanged.
  always_comb begin
    r_sum = '0;
    for (int k = 0; k < SHARES - 1; k++) begin
      r_sum = r_sum ^ io._RxDI[4*k +: 4];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SHARES; gi++) begin : g_share
      logic [3:0] p_raw;
      assign p_raw = {io._BmulExDI[2*gi +: 2], io._AmulExDI[2*gi +: 2]};
      if (gi < SHARES - 1) begin : g_mid
        assign ref_share[gi] = p_raw ^ io._RxDI[4*gi +: 4];
      end else begin : g_last
        assign ref_share[gi] = p_raw ^ r_sum;
      end
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    for (int k = 0; k < SHARES; k++) begin
      if (stage_valid) begin
        q_d[4*k +: 4] = ref_share[k];
      end
    end
  end

  assign valid_out_d = stage_valid;

  // Occupancy: tokens in the shift register plus the one presented at the output.
  always_comb begin
    occ_cnt_d = occ_cnt_q;
    if (io.ValidxSI && !valid_out_q) begin
      if (occ_cnt_q != CNT_MAX) begin
        occ_cnt_d = occ_cnt_q + CNT_W'(1);
      end
    end else if (!io.ValidxSI && valid_out_q) begin
      if (occ_cnt_q != '0) begin
        occ_cnt_d = occ_cnt_q - CNT_W'(1);
      end
    end
  end

  assign busy_d = (occ_cnt_d != '0);

  always_ff @(posedge ClkxCI or posedge RstxBI) begin
    if (RstxBI) begin
      valid_sr_q  <= '0;
      q_q         <= '0;
      valid_out_q <= 1'b0;
      occ_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      valid_sr_q  <= valid_sr_d;
      q_q         <= q_d;
      valid_out_q <= valid_out_d;
      occ_cnt_q   <= occ_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign io._QxDO    = q_q;
  assign io.ValidxSO = valid_out_q;
  assign io.BusyxSO  = busy_q;

endmodule

// File: tb/tb_real_dom_gf4_inv_out_stage.sv
// Randomized bench for two configurations (SHARES=2/LATENCY_IN=2, SHARES=3/LATENCY_IN=1)
// against a history-based reference model of the output stage.
module tb_real_dom_gf4_inv_out_stage;

  localparam int HMAX = 1024;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  real_dom_gf4_inv_out_stage_if #(.SHARES(2)) if2 ();
  real_dom_gf4_inv_out_stage_if #(.SHARES(3)) if3 ();

  real_dom_gf4_inv_out_stage #(.SHARES(2), .LATENCY_IN(2)) dut2 (
    .ClkxCI (clk),
    .RstxBI (rst),
    .io     (if2)
  );

  real_dom_gf4_inv_out_stage #(.SHARES(3), .LATENCY_IN(1)) dut3 (
    .ClkxCI (clk),
    .RstxBI (rst),
    .io     (if3)
  );

  // Input history per configuration, indexed by cycle number.
  logic       vin_h [2][HMAX];
  logic [5:0] a_h   [2][HMAX];
  logic [5:0] b_h   [2][HMAX];
  logic [7:0] r_h   [2][HMAX];
  logic       rst_h [HMAX];

  logic [11:0] q_m [2];
  int cyc;
  int last_rst;
  int total;
  int bad;
  int peak2;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Refresh rule: share i gets R_i, the last share gets the XOR of all R words.
  function automatic logic [11:0] ref_q(input int sh, input logic [5:0] a, input logic [5:0] b,
                                        input logic [7:0] r);
    logic [3:0] rsum;
    logic [3:0] p;
    logic [11:0] res;
    res  = '0;
    rsum = '0;
    for (int i = 0; i < sh - 1; i++) rsum = rsum ^ r[4*i +: 4];
    for (int i = 0; i < sh; i++) begin
      p = {b[2*i +: 2], a[2*i +: 2]};
      if (i < sh - 1) res[4*i +: 4] = p ^ r[4*i +: 4];
      else            res[4*i +: 4] = p ^ rsum;
    end
    return res;
  endfunction

  function automatic logic [3:0] fold_q(input logic [11:0] q, input int sh);
    logic [3:0] x;
    x = '0;
    for (int i = 0; i < sh; i++) x = x ^ q[4*i +: 4];
    return x;
  endfunction

  function automatic logic [3:0] unmasked(input logic [5:0] a, input logic [5:0] b, input int sh);
    logic [1:0] xa;
    logic [1:0] xb;
    xa = '0;
    xb = '0;
    for (int i = 0; i < sh; i++) begin
      xa = xa ^ a[2*i +: 2];
      xb = xb ^ b[2*i +: 2];
    end
    return {xb, xa};
  endfunction

  task automatic model_cfg(input int k, input logic vo, input logic bo, input logic [11:0] qo,
                           input int occ_o);
    int sh;
    int lat;
    int iss;
    int lo;
    int occ_e;
    logic s;
    sh  = (k == 0) ? 2 : 3;
    lat = (k == 0) ? 2 : 1;
    iss = cyc - 1 - lat;
    s   = (iss >= 0) && (iss > last_rst) && vin_h[k][iss];
    if (rst_h[cyc-1])
      q_m[k] = '0;
    else if (s)
      q_m[k] = ref_q(sh, a_h[k][cyc-1], b_h[k][cyc-1], r_h[k][cyc-1]);
    lo = cyc - 1 - lat;
    if (lo < last_rst + 1) lo = last_rst + 1;
    if (lo < 0) lo = 0;
    occ_e = 0;
    for (int i = lo; i <= cyc - 1; i++) if (vin_h[k][i]) occ_e++;
    check_val($sformatf("cfg%0d_valid c%0d", k, cyc), 32'(vo), 32'(s));
    check_val($sformatf("cfg%0d_busy c%0d", k, cyc), 32'(bo), 32'(occ_e != 0));
    check_val($sformatf("cfg%0d_q c%0d", k, cyc), 32'(qo), 32'(q_m[k]));
    check_val($sformatf("cfg%0d_occ c%0d", k, cyc), 32'(occ_o), 32'(occ_e));
    if (s) begin
      check_val($sformatf("cfg%0d_xor c%0d", k, cyc), 32'(fold_q(qo, sh)),
                32'(unmasked(a_h[k][cyc-1], b_h[k][cyc-1], sh)));
      if (vo) $display("txn cfg%0d cyc=%0d q=%h", k, cyc, qo);
    end
    if (k == 0 && occ_o > peak2) peak2 = occ_o;
  endtask

  task automatic step(input logic rst_i,
                      input logic v0, input logic [5:0] a0, input logic [5:0] b0, input logic [7:0] r0,
                      input logic v1, input logic [5:0] a1, input logic [5:0] b1, input logic [7:0] r1);
    @(negedge clk);
    cyc++;
    if (cyc >= HMAX) begin
      $display("FAIL history_overflow got=%0d exp<%0d", cyc, HMAX);
      $fatal(1, "history overflow");
    end
    if (rst_h[cyc-1]) last_rst = cyc - 1;
    model_cfg(0, if2.ValidxSO, if2.BusyxSO, {4'b0, if2._QxDO}, int'(dut2.occ_cnt_q));
    model_cfg(1, if3.ValidxSO, if3.BusyxSO, if3._QxDO, int'(dut3.occ_cnt_q));
    rst           = rst_i;
    if2.ValidxSI  = v0;
    if2._AmulExDI = a0[3:0];
    if2._BmulExDI = b0[3:0];
    if2._RxDI     = r0[3:0];
    if3.ValidxSI  = v1;
    if3._AmulExDI = a1;
    if3._BmulExDI = b1;
    if3._RxDI     = r1;
    rst_h[cyc]    = rst_i;
    vin_h[0][cyc] = v0;
    a_h[0][cyc]   = {2'b0, a0[3:0]};
    b_h[0][cyc]   = {2'b0, b0[3:0]};
    r_h[0][cyc]   = {4'b0, r0[3:0]};
    vin_h[1][cyc] = v1;
    a_h[1][cyc]   = a1;
    b_h[1][cyc]   = b1;
    r_h[1][cyc]   = r1;
  endtask

  task automatic step_rand(input logic rst_i, input logic v0, input logic v1);
    step(rst_i, v0, 6'($urandom), 6'($urandom), 8'($urandom),
                v1, 6'($urandom), 6'($urandom), 8'($urandom));
  endtask

  int cnt;

  initial begin
    total    = 0;
    bad      = 0;
    cyc      = 0;
    last_rst = -1;
    peak2    = 0;
    q_m[0]   = '0;
    q_m[1]   = '0;
    rst           = 1'b1;
    if2.ValidxSI  = 1'b0;
    if2._AmulExDI = '0;
    if2._BmulExDI = '0;
    if2._RxDI     = '0;
    if3.ValidxSI  = 1'b0;
    if3._AmulExDI = '0;
    if3._BmulExDI = '0;
    if3._RxDI     = '0;
    rst_h[0]    = 1'b1;
    vin_h[0][0] = 1'b0;
    vin_h[1][0] = 1'b0;
    a_h[0][0] = '0; b_h[0][0] = '0; r_h[0][0] = '0;
    a_h[1][0] = '0; b_h[1][0] = '0; r_h[1][0] = '0;

    // Reset held with toggling inputs.
    for (int i = 0; i < 6; i++) begin
      step_rand(1'b1, 1'($urandom), 1'($urandom));
      check_val("reset_q", 32'(if2._QxDO), 32'h0);
      check_val("reset_busy", 32'(if2.BusyxSO), 32'h0);
    end
    step_rand(1'b0, 1'b0, 1'b0);
    step_rand(1'b0, 1'b0, 1'b0);

    // Single token with known shares.
    step_rand(1'b0, 1'b1, 1'b0);
    step_rand(1'b0, 1'b0, 1'b0);
    check_val("single_busy_t1", 32'(if2.BusyxSO), 32'h1);
    step(1'b0, 1'b0, 6'b00_0110, 6'b00_0011, 8'h05, 1'b0, 6'h0, 6'h0, 8'h0);
    check_val("single_busy_t2", 32'(if2.BusyxSO), 32'h1);
    check_val("single_valid_t2", 32'(if2.ValidxSO), 32'h0);
    step_rand(1'b0, 1'b0, 1'b0);
    check_val("single_busy_t3", 32'(if2.BusyxSO), 32'h1);
    check_val("single_valid_t3", 32'(if2.ValidxSO), 32'h1);
    check_val("single_q_t3", 32'(if2._QxDO), 32'h4B);
    step_rand(1'b0, 1'b0, 1'b0);
    check_val("single_busy_t4", 32'(if2.BusyxSO), 32'h0);
    check_val("single_valid_t4", 32'(if2.ValidxSO), 32'h0);

    // Hold: inputs change with no new tokens.
    for (int i = 0; i < 4; i++) begin
      step_rand(1'b0, 1'b0, 1'b0);
      check_val("hold_q", 32'(if2._QxDO), 32'h4B);
      check_val("hold_valid", 32'(if2.ValidxSO), 32'h0);
    end

    // Streaming: 8 back-to-back tokens on both configurations.
    peak2 = 0;
    cnt   = 0;
    for (int i = 0; i < 8; i++) begin
      step_rand(1'b0, 1'b1, 1'b1);
      if (if2.ValidxSO) cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      step_rand(1'b0, 1'b0, 1'b0);
      if (if2.ValidxSO) cnt++;
    end
    check_val("stream_count", 32'(cnt), 32'd8);
    check_val("stream_peak", 32'(peak2), 32'd3);

    // Reset one cycle after the second of two tokens.
    step_rand(1'b0, 1'b1, 1'b1);
    step_rand(1'b0, 1'b1, 1'b1);
    step_rand(1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step_rand(1'b0, 1'b0, 1'b0);
      if (if2.ValidxSO || if3.ValidxSO) cnt++;
    end
    check_val("midrst_valids", 32'(cnt), 32'd0);
    check_val("midrst_busy", 32'(if2.BusyxSO), 32'h0);
    check_val("midrst_occ", 32'(dut2.occ_cnt_q), 32'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step_rand(1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 9) < 6),
                1'($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) step_rand(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
